// File: rtl/async_fifo_pkg.sv
// Shared constants for the single-clock FIFO: default geometry and pointer width.
package async_fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;
  localparam int PTR_W     = ASIZE_DEF + 1;
endpackage

// File: rtl/fifo_mem.sv
// 2^ASIZE x DSIZE storage: synchronous write port, combinational read port.
module fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [2**ASIZE];

  // No reset on the array: contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wclken) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with show-ahead read data and registered full/empty flags
// derived from the next-state pointers, so the flags are exact one cycle later.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);
  localparam int PW = ASIZE + 1;

  logic [PW-1:0] wptr, rptr, wptr_next, rptr_next;
  logic          do_write, do_read;

  // Handshake: a push takes effect on any edge where winc=1 and wfull=0; a pop
  // takes effect where rinc=1 and rempty=0. Requests against a blocked side are dropped.
  always_comb begin
    do_write  = winc && !wfull;
    do_read   = rinc && !rempty;
    wptr_next = wptr + PW'(do_write);
    rptr_next = rptr + PW'(do_read);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      wfull  <= 1'b0;
      rempty <= 1'b1;
    end else begin
      wptr   <= wptr_next;
      rptr   <= rptr_next;
      rempty <= (rptr_next == wptr_next);
      // Same slot address but different wrap bit means the writer is a lap ahead.
      wfull  <= (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
    end
  end

  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk    (clk),
    .wclken (do_write && !rst),
    .waddr  (wptr[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr[ASIZE-1:0]),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: randomized traffic scored against a queue model of FIFO order.
module tb_async_fifo;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             winc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             wfull;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] rdata;
  logic             rempty;

  logic [DSIZE-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  // Drive one cycle of requests and advance the model. Called at posedge+1;
  // returns at the next posedge+1. got/want carry the head word seen before a pop.
  task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r,
                      output logic popped, output logic [DSIZE-1:0] got,
                      output logic [DSIZE-1:0] want);
    logic will_w, will_r;
    will_w = w && (exp_q.size() < DEPTH);
    will_r = r && (exp_q.size() != 0);
    popped = will_r;
    got    = rdata;
    want   = will_r ? exp_q[0] : '0;
    winc = w; wdata = d; rinc = r;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0;
    if (will_r) void'(exp_q.pop_front());
    if (will_w) exp_q.push_back(d);
  endtask

  task automatic apply_reset(input int n, input logic w, input logic r);
    rst = 1'b1; winc = w; rinc = r; wdata = 8'hEE;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic p; logic [DSIZE-1:0] g, e;
    apply_reset(5, 1'b0, 1'b0);
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%b exp=1", rempty); end
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%b exp=0", wfull); end
    step(1'b0, '0, 1'b1, p, g, e);
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL reset_underflow_rempty got=%b exp=1", rempty); end
    step(1'b1, 8'h11, 1'b0, p, g, e);
    checks++; if (rdata !== 8'h11) begin failures++; $display("FAIL reset_rptr_zero got=%0h exp=11", rdata); end
    step(1'b0, '0, 1'b1, p, g, e);
  endtask

  task automatic test_single();
    logic p; logic [DSIZE-1:0] g, e;
    step(1'b1, 8'h2A, 1'b0, p, g, e);
    checks++; if (rempty !== 1'b0) begin failures++; $display("FAIL single_rempty got=%b exp=0", rempty); end
    checks++; if (rdata !== 8'h2A) begin failures++; $display("FAIL single_rdata got=%0h exp=2a", rdata); end
    step(1'b0, '0, 1'b1, p, g, e);
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL single_drain got=%b exp=1", rempty); end
  endtask

  task automatic test_fill_overflow();
    logic p; logic [DSIZE-1:0] g, e;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL fill_early_full i=%0d got=%b exp=0", i, wfull); end
      step(1'b1, DSIZE'(i), 1'b0, p, g, e);
    end
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL fill_wfull got=%b exp=1", wfull); end
    step(1'b1, 8'hFF, 1'b0, p, g, e);
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL overflow_wfull got=%b exp=1", wfull); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, p, g, e);
      checks++; if (g !== DSIZE'(i)) begin failures++; $display("FAIL drain_order i=%0d got=%0h exp=%0h", i, g, i); end
    end
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL drain_rempty got=%b exp=1", rempty); end
  endtask

  task automatic test_alternating();
    logic p; logic [DSIZE-1:0] g, e;
    int writes = 0;
    for (int cyc = 0; cyc < 80 && (writes < 16 || exp_q.size() != 0); cyc++) begin
      logic w;
      w = (cyc % 2 == 0) && (writes < 16);
      if (w) writes++;
      step(w, DSIZE'($urandom_range(0, 199)), exp_q.size() != 0, p, g, e);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL alt_data cyc=%0d got=%0h exp=%0h", cyc, g, e); end
      end
    end
    checks++; if (writes != 16 || exp_q.size() != 0) begin failures++; $display("FAIL alt_budget got=%0d/%0d exp=16/0", writes, exp_q.size()); end
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL alt_rempty got=%b exp=1", rempty); end
  endtask

  task automatic test_simultaneous();
    logic p; logic [DSIZE-1:0] g, e;
    for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'(8'h40 + i), 1'b0, p, g, e);
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL simul_pre_full got=%b exp=1", wfull); end
    step(1'b1, 8'hAA, 1'b1, p, g, e);
    checks++; if (g !== 8'h40) begin failures++; $display("FAIL simul_full_pop got=%0h exp=40", g); end
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL simul_full_wfull got=%b exp=0", wfull); end
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, p, g, e);
      checks++; if (g !== DSIZE'(8'h40 + i)) begin failures++; $display("FAIL simul_full_drop i=%0d got=%0h exp=%0h", i, g, 8'h40 + i); end
    end
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL simul_pre_empty got=%b exp=1", rempty); end
    step(1'b1, 8'h55, 1'b1, p, g, e);
    checks++; if (rempty !== 1'b0) begin failures++; $display("FAIL simul_empty_rempty got=%b exp=0", rempty); end
    checks++; if (rdata !== 8'h55) begin failures++; $display("FAIL simul_empty_rdata got=%0h exp=55", rdata); end
    step(1'b0, '0, 1'b1, p, g, e);
  endtask

  task automatic test_wrap();
    logic p; logic [DSIZE-1:0] g, e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'($urandom), 1'b0, p, g, e);
      checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL wrap_full pass=%0d got=%b exp=1", pass, wfull); end
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b0, '0, 1'b1, p, g, e);
        checks++; if (g !== e) begin failures++; $display("FAIL wrap_data pass=%0d i=%0d got=%0h exp=%0h", pass, i, g, e); end
      end
      checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL wrap_empty pass=%0d got=%b exp=1", pass, rempty); end
    end
  endtask

  task automatic test_random();
    logic p; logic [DSIZE-1:0] g, e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step(($urandom_range(0, 99) < 55), DSIZE'($urandom), ($urandom_range(0, 99) < 45), p, g, e);
      if (p) begin
        checks++; if (g !== e) begin failures++; $display("FAIL rand_data cyc=%0d got=%0h exp=%0h", cyc, g, e); end
      end
      checks++;
      if (rempty !== (exp_q.size() == 0) || wfull !== (exp_q.size() == DEPTH)) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=e%b/f%b exp_count=%0d", cyc, rempty, wfull, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic p; logic [DSIZE-1:0] g, e;
    for (int i = 0; i < 7; i++) step(1'b1, DSIZE'($urandom), 1'b0, p, g, e);
    apply_reset(1, 1'b1, 1'b1);
    checks++; if (rempty !== 1'b1 || wfull !== 1'b0) begin failures++; $display("FAIL midreset_flags got=e%b/f%b exp=e1/f0", rempty, wfull); end
    step(1'b1, 8'h77, 1'b0, p, g, e);
    step(1'b0, '0, 1'b1, p, g, e);
    checks++; if (g !== 8'h77) begin failures++; $display("FAIL midreset_data got=%0h exp=77", g); end
    checks++; if (rempty !== 1'b1) begin failures++; $display("FAIL midreset_empty got=%b exp=1", rempty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_alternating();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
